// File: rtl/rle_compress_handler.sv
// Run-length encoder: reads raw bytes through the DMA handshake and writes
// (count, value) byte pairs to a destination region.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for start
// RD_REQ      | raise read request for src_ptr
// RD_WAIT     | wait for read completion, extend or close the current run
// WR_CNT      | raise write request for the run count
// WR_CNT_WAIT | wait for count write completion
// WR_VAL      | raise write request for the run value
// WR_VAL_WAIT | wait for value write completion, continue with pending byte
// DONE        | emit the one-cycle done pulse
module rle_compress_handler #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MAX_RUN = 255
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] src_len,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] out_len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_read,
  output logic              ram_write,
  input  logic              ram_done_read,
  input  logic              ram_done_write
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_CNT, WR_CNT_WAIT, WR_VAL, WR_VAL_WAIT, DONE
  } state_t;

  localparam logic [DATA_W-1:0] MAX_RUN_W = DATA_W'(MAX_RUN);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] out_len_q, out_len_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] run_q, run_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pending_q, pending_d;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      out_len_q   <= '0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      val_q       <= '0;
      run_q       <= '0;
      pend_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      out_len_q   <= out_len_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      val_q       <= val_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    out_len_d   = out_len_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    val_d       = val_q;
    run_d       = run_q;
    pend_d      = pend_q;
    pending_d   = pending_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d   = src_base;
          dst_ptr_d   = dst_base;
          remaining_d = src_len;
          out_len_d   = '0;
          run_d       = '0;
          pending_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = (src_len == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        ram_read_d = 1'b1;
        ram_addr_d = src_ptr_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_done_read && ram_read_q) begin
          ram_read_d  = 1'b0;
          src_ptr_d   = src_ptr_q + ONE_A;
          remaining_d = remaining_q - ONE_A;
          // run_q == 0 only before the first byte of a job
          if (run_q == '0) begin
            val_d   = ram_rdata;
            run_d   = {{(DATA_W-1){1'b0}}, 1'b1};
            state_d = (remaining_q != ONE_A) ? RD_REQ : WR_CNT;
          end else if (ram_rdata == val_q && run_q < MAX_RUN_W) begin
            run_d   = run_q + {{(DATA_W-1){1'b0}}, 1'b1};
            state_d = (remaining_q != ONE_A) ? RD_REQ : WR_CNT;
          end else begin
            pend_d    = ram_rdata;
            pending_d = 1'b1;
            state_d   = WR_CNT;
          end
        end
      end
      WR_CNT: begin
        ram_write_d = 1'b1;
        ram_addr_d  = dst_ptr_q;
        ram_wdata_d = run_q;
        state_d     = WR_CNT_WAIT;
      end
      WR_CNT_WAIT: begin
        if (ram_done_write && ram_write_q) begin
          ram_write_d = 1'b0;
          dst_ptr_d   = dst_ptr_q + ONE_A;
          state_d     = WR_VAL;
        end
      end
      WR_VAL: begin
        ram_write_d = 1'b1;
        ram_addr_d  = dst_ptr_q;
        ram_wdata_d = val_q;
        state_d     = WR_VAL_WAIT;
      end
      WR_VAL_WAIT: begin
        if (ram_done_write && ram_write_q) begin
          ram_write_d = 1'b0;
          dst_ptr_d   = dst_ptr_q + ONE_A;
          out_len_d   = out_len_q + ADDR_W'(2);
          if (pending_q) begin
            val_d     = pend_q;
            run_d     = {{(DATA_W-1){1'b0}}, 1'b1};
            pending_d = 1'b0;
            state_d   = (remaining_q != '0) ? RD_REQ : WR_CNT;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Entered from IDLE (empty job) without the pulse raised yet.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_len   = out_len_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;

endmodule

// File: tb/tb_rle_compress_handler.sv
// Directed bench for rle_compress_handler: table of jobs against a byte RAM
// model with a delayed DMA responder, plus reset/start corner sequences.
module tb_rle_compress_handler;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_base = '0, src_len = '0, dst_base = '0;
  logic        busy, done;
  logic [15:0] out_len, ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        ram_read, ram_write;
  logic        ram_done_read = 1'b0, ram_done_write = 1'b0;

  rle_compress_handler #(.ADDR_W(16), .DATA_W(8), .MAX_RUN(255)) dut (
    .clk(clk), .RST(RST), .start(start), .src_base(src_base), .src_len(src_len),
    .dst_base(dst_base), .busy(busy), .done(done), .out_len(out_len),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_read(ram_read), .ram_write(ram_write),
    .ram_done_read(ram_done_read), .ram_done_write(ram_done_write)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, max_dly = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int done_cyc = 0, last_wd_cyc = 0, start_cyc = 0;
  bit overlap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ram_done_write) last_wd_cyc = cyc;
    if (ram_read && ram_write) overlap = 1'b1;
  end

  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (ram_read) begin
        d = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
        repeat (d) begin @(posedge clk); #1; end
        if (ram_read) begin ram_rdata = mem[ram_addr]; rd_cnt++; end
        ram_done_read = 1'b1;
        @(posedge clk); #1;
        ram_done_read = 1'b0;
      end
    end
  end

  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (ram_write) begin
        d = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
        repeat (d) begin @(posedge clk); #1; end
        if (ram_write) begin mem[ram_addr] = ram_wdata; wr_cnt++; end
        ram_done_write = 1'b1;
        @(posedge clk); #1;
        ram_done_write = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] sb, input logic [15:0] len, input logic [15:0] db);
    @(negedge clk);
    src_base = sb; src_len = len; dst_base = db; start = 1'b1;
    start_cyc = cyc;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output bit busy_at_done);
    bit seen = 1'b0;
    busy_at_done = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin seen = 1'b1; busy_at_done = busy; break; end
      @(negedge clk);
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string       nm;
    logic [15:0] sb;
    int          len;
    logic [63:0] src;
    logic [15:0] db;
    int          elen;
    logic [63:0] ex;
    int          dly;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [15:0] sb, input int len,
                              input logic [63:0] src, input logic [15:0] db,
                              input int elen, input logic [63:0] ex, input int dly);
    vec_t v;
    v.nm = nm; v.sb = sb; v.len = len; v.src = src; v.db = db;
    v.elen = elen; v.ex = ex; v.dly = dly;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check_region(input string name, input logic [15:0] db, input int n,
                              input logic [63:0] ex);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = db + 16'(i);
      chk($sformatf("%s byte%0d", name, i), 32'(mem[a]), 32'(ex[63-8*i -: 8]));
    end
    a = db + 16'(n);
    chk({name, " no_extra_write"}, 32'(mem[a]), 32'hEE);
  endtask

  initial begin
    logic [15:0] a;
    bit          bz;
    bit          req_seen;

    vecs[0] = mk("t1_basic",   16'h1000, 4, 64'h05050507_00000000, 16'h0100, 4, 64'h03050107_00000000, 0);
    vecs[1] = mk("t4_alt",     16'h1040, 4, 64'h01020102_00000000, 16'h0200, 8, 64'h01010102_01010102, 0);
    vecs[2] = mk("t4_alt_dly", 16'h1040, 4, 64'h01020102_00000000, 16'h0210, 8, 64'h01010102_01010102, 5);
    vecs[3] = mk("t5_dstwrap", 16'h1080, 3, 64'h090904_0000000000, 16'hFFFE, 4, 64'h02090104_00000000, 0);
    vecs[4] = mk("single",     16'h10C0, 1, 64'h00_00000000000000, 16'h0400, 2, 64'h0100_000000000000, 1);
    vecs[5] = mk("t2_empty",   16'h1100, 0, 64'h0,                  16'h0410, 0, 64'h0,                  0);
    vecs[6] = mk("run8",       16'h1140, 8, 64'h07070707_07070707, 16'h0420, 2, 64'h0807_000000000000, 2);
    vecs[7] = mk("distinct3",  16'h1180, 3, 64'h010203_0000000000, 16'h0440, 6, 64'h01010102_01030000, 0);
    vecs[8] = mk("srcwrap",    16'hFFFF, 2, 64'h0A0A_000000000000, 16'h0500, 2, 64'h020A_000000000000, 3);

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst busy",      32'(busy), 0);
    chk("rst done",      32'(done), 0);
    chk("rst ram_read",  32'(ram_read), 0);
    chk("rst ram_write", 32'(ram_write), 0);
    chk("rst ram_addr",  32'(ram_addr), 0);
    chk("rst ram_wdata", 32'(ram_wdata), 0);
    chk("rst out_len",   32'(out_len), 0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      max_dly = vecs[k].dly;
      for (int i = 0; i < vecs[k].len; i++) begin
        a = vecs[k].sb + 16'(i);
        mem[a] = vecs[k].src[63-8*i -: 8];
      end
      for (int i = 0; i <= vecs[k].elen; i++) begin
        a = vecs[k].db + 16'(i);
        mem[a] = 8'hEE;
      end
      start_job(vecs[k].sb, 16'(vecs[k].len), vecs[k].db);
      wait_done(vecs[k].nm, bz);
      chk({vecs[k].nm, " busy_at_done"}, 32'(bz), 0);
      chk({vecs[k].nm, " out_len"}, 32'(out_len), 32'(vecs[k].elen));
      chk({vecs[k].nm, " done_pulses"}, 32'(done_cnt), 1);
      chk({vecs[k].nm, " reads"}, 32'(rd_cnt), 32'(vecs[k].len));
      chk({vecs[k].nm, " writes"}, 32'(wr_cnt), 32'(vecs[k].elen));
      check_region(vecs[k].nm, vecs[k].db, vecs[k].elen, vecs[k].ex);
      if (vecs[k].len == 0)
        chk({vecs[k].nm, " latency"}, 32'(done_cyc - start_cyc), 2);
      else if (vecs[k].dly == 0)
        chk({vecs[k].nm, " latency"}, 32'(done_cyc - last_wd_cyc), 1);
    end

    // 300 bytes of AA: run split at 255.
    max_dly = 1;
    for (int i = 0; i < 300; i++) begin
      a = 16'h2000 + 16'(i);
      mem[a] = 8'hAA;
    end
    for (int i = 0; i < 5; i++) begin
      a = 16'h0800 + 16'(i);
      mem[a] = 8'hEE;
    end
    start_job(16'h2000, 16'd300, 16'h0800);
    wait_done("t3_maxrun", bz);
    chk("t3_maxrun out_len", 32'(out_len), 4);
    check_region("t3_maxrun", 16'h0800, 4, 64'hFFAA2DAA_00000000);

    // start pulsed while busy must not disturb the running job.
    max_dly = 2;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0600 + 16'(i);
      mem[a] = 8'hEE;
    end
    mem[16'h0604] = 8'hEE;
    mem[16'h0700] = 8'hEE;
    start_job(16'h1000, 16'd4, 16'h0600);
    repeat (4) @(negedge clk);
    src_base = 16'h1080; src_len = 16'd1; dst_base = 16'h0700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_ignore", bz);
    chk("t6_ignore out_len", 32'(out_len), 4);
    chk("t6_ignore done_pulses", 32'(done_cnt), 1);
    chk("t6_ignore other_dst", 32'(mem[16'h0700]), 32'hEE);
    check_region("t6_ignore", 16'h0600, 4, 64'h03050107_00000000);

    // Reset during the value write wait.
    max_dly = 3;
    start_job(16'h1000, 16'd4, 16'h0300);
    bz = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wr_cnt == 1 && ram_write) begin bz = 1'b1; break; end
    end
    chk("t6_rst reached_wr_val", 32'(bz), 1);
    RST = 1'b0;
    #1;
    chk("t6_rst busy",      32'(busy), 0);
    chk("t6_rst ram_write", 32'(ram_write), 0);
    chk("t6_rst ram_addr",  32'(ram_addr), 0);
    chk("t6_rst ram_wdata", 32'(ram_wdata), 0);
    chk("t6_rst out_len",   32'(out_len), 0);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      req_seen = req_seen | ram_read | ram_write | busy;
    end
    chk("t6_rst no_resume", 32'(req_seen), 0);

    for (int i = 0; i < 5; i++) begin
      a = 16'h0300 + 16'(i);
      mem[a] = 8'hEE;
    end
    start_job(16'h1000, 16'd4, 16'h0300);
    wait_done("t6_after", bz);
    chk("t6_after out_len", 32'(out_len), 4);
    chk("t6_after done_pulses", 32'(done_cnt), 1);
    check_region("t6_after", 16'h0300, 4, 64'h03050107_00000000);

    chk("rw_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
